conv_layer_seq: RTL and testbench
=================================

# conv_layer_seq

Layer sequencer for the convolution accelerator. It runs one multi-layer inference per start command. For each layer it drives the input buffer's load-state and current-layer selectors through a parameter-load phase, then a feature-data phase, and waits for the input buffer's last-layer-done pulse. Between layers it inserts a fixed drain gap so the output buffer can flush. It sits between the AXI-Lite register block and `in_buffer`, and adds completion, interrupt and watchdog-error reporting.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 4: idle cycles between layers (1..255).
- `TIMEOUT_W`, default 24: watchdog counter width; timeout fires at 2^TIMEOUT_W − 1 cycles in one phase.

Ports:
- `s_axi_aclk` in 1: sole clock.
- `s_axi_aresetn` in 1: asynchronous, active-low reset.
- `i_start` in 1: one-cycle start pulse.
- `i_abort` in 1: one-cycle abort pulse; also clears sticky status.
- `i_num_layers` in 2: layer count minus one (0 → 1 layer, 3 → 4 layers); latched on start.
- `i_param_loaded` in 1: pulse from the input buffer; parameters for the current layer are stored.
- `i_last` in 1: pulse from the input buffer; current layer is complete.
- `o_load_state` out 1: 0 = parameter load, 1 = feature load.
- `o_current_layer` out 2: index of the active layer.
- `o_busy` out 1: sequence in progress.
- `o_done` out 1: sticky; last sequence completed.
- `o_err` out 1: sticky; watchdog timeout occurred.
- `o_irq` out 1: one-cycle pulse on entering DONE or ERROR.
- `o_run_cycles` out 32: performance counter (see Configuration).

## Operation
- States: IDLE, LOAD_PARAM, LOAD_DATA, DRAIN, DONE, ERROR.
- IDLE:
  - `i_start` → LOAD_PARAM.
  - On that start, layer ← 0, `i_num_layers` latched, `o_done` and `o_err` cleared.
- LOAD_PARAM (`o_load_state`=0):
  - `i_param_loaded` → LOAD_DATA.
  - `i_last` is ignored in this state.
- LOAD_DATA (`o_load_state`=1), on `i_last`:
  - If layer == latched count → DONE.
  - Otherwise → DRAIN.
- DRAIN (`o_load_state`=0):
  - Counts DRAIN_CYCLES cycles.
  - Then layer ← layer+1 → LOAD_PARAM.
- DONE (one cycle): `o_done` ← 1, `o_irq` pulses, → IDLE.
- Watchdog:
  - The counter clears on every state transition and increments in LOAD_PARAM and LOAD_DATA.
  - At all-ones → ERROR.
- ERROR:
  - On entry: `o_err` ← 1, `o_irq` pulses.
  - `o_load_state`=0; the state is held until `i_abort`.
  - `i_start` is ignored.
- `i_abort` in any state:
  - → IDLE next cycle.
  - Clears `o_done` and `o_err`; layer ← 0.
- `i_start` while busy, DONE or ERROR is ignored.
- `o_busy` = 1 in LOAD_PARAM, LOAD_DATA and DRAIN.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `o_load_state`=0, `o_current_layer`=0, `o_busy`=0, `o_done`=0, `o_err`=0, `o_irq`=0, `o_run_cycles`=0.
- Latencies:
  - `i_start` at cycle N → `o_busy`=1 and LOAD_PARAM at N+1.
  - `i_param_loaded` at N → `o_load_state`=1 at N+1.
  - Final `i_last` at N → `o_irq`=1 and `o_done`=1 at N+1, `o_busy`=0 at N+1.
  - Non-final `i_last` at N → DRAIN at N+1; `o_current_layer` increments at N+1+DRAIN_CYCLES.
- Simultaneous events:
  - `i_abort` with `i_start`: abort wins, state stays IDLE.
  - `i_last` with timeout in LOAD_DATA: `i_last` wins.
  - `i_param_loaded` with `i_last` in LOAD_PARAM: go to LOAD_DATA, `i_last` dropped.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous).

## Configuration
- `CONV_LAYER_SEQ_PERF_EN` defined:
  - `o_run_cycles` counts cycles with `o_busy`=1.
  - Cleared on accepted start, saturates at 0xFFFFFFFF, holds after DONE or ERROR.
- Not defined: `o_run_cycles` tied to 0 and no counter is synthesized. The port is always present.

## Structure
- Shared package `conv_pkg` holds:
  - State encoding (3-bit localparams).
  - Layer index width (2).
  - Load-state encodings `LS_PARAM`=0 and `LS_DATA`=1, also used by `in_buffer`.
- One sub-module, `seq_watchdog`:
  - TIMEOUT_W counter with clear and enable inputs and a registered expire output.
  - Instantiated once.

## Test plan
- Single layer: `i_num_layers`=0, start, `i_param_loaded` after 10 cycles, `i_last` after 50 more → `o_load_state` 0→1, `o_irq` one pulse, `o_done`=1, `o_current_layer`=0.
- Four layers: `i_num_layers`=3 → `o_current_layer` steps 0,1,2,3, each step 4 cycles after `i_last`; one `o_irq` total; `o_run_cycles` equals the busy-cycle count (PERF_EN).
- Timeout: TIMEOUT_W=6, start with no `i_param_loaded` → ERROR after 63 cycles, `o_err`=1, `o_irq` pulse; `i_start` ignored; `i_abort` → IDLE, `o_err`=0.
- Abort mid-sequence in LOAD_DATA of layer 2 → next cycle `o_busy`=0, `o_current_layer`=0, no `o_irq`.
- Same-cycle `i_start`+`i_abort` in IDLE → stays IDLE; `i_start` while busy → layer count and index unchanged.
- Reset asserted during DRAIN → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared encodings for the convolution accelerator layer sequencer and in_buffer.
//   ST_*      3-bit sequencer state codes (wrapped by state_t)
//   LAYER_W   layer index width
//   LS_PARAM / LS_DATA  in_buffer load-state selector values
package conv_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD_PARAM = 3'd1;
    localparam logic [2:0] ST_LOAD_DATA  = 3'd2;
    localparam logic [2:0] ST_DRAIN      = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;
    localparam logic [2:0] ST_ERROR      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_LOAD_PARAM = ST_LOAD_PARAM,
        S_LOAD_DATA  = ST_LOAD_DATA,
        S_DRAIN      = ST_DRAIN,
        S_DONE       = ST_DONE,
        S_ERROR      = ST_ERROR
    } state_t;

    localparam int LAYER_W = 2;

    localparam logic LS_PARAM = 1'b0;
    localparam logic LS_DATA  = 1'b1;

    function automatic logic is_busy(input state_t s);
        return s == S_LOAD_PARAM || s == S_LOAD_DATA || s == S_DRAIN;
    endfunction

    // Phases that wait on the input buffer and so are guarded by the watchdog.
    function automatic logic is_watched(input state_t s);
        return s == S_LOAD_PARAM || s == S_LOAD_DATA;
    endfunction

endpackage

// File: rtl/conv_layer_seq_if.sv
// conv_layer_seq_if: control/status bundle between register block, in_buffer and the layer sequencer.
//   i_start, i_abort, i_num_layers   command side (register block)
//   i_param_loaded, i_last           in_buffer progress pulses
//   o_load_state, o_current_layer    in_buffer selectors
//   o_busy, o_done, o_err, o_irq, o_run_cycles  status
//   master: drives commands/pulses; slave: the sequencer
interface conv_layer_seq_if;
    import conv_pkg::*;

    logic               i_start;
    logic               i_abort;
    logic [LAYER_W-1:0] i_num_layers;
    logic               i_param_loaded;
    logic               i_last;
    logic               o_load_state;
    logic [LAYER_W-1:0] o_current_layer;
    logic               o_busy;
    logic               o_done;
    logic               o_err;
    logic               o_irq;
    logic [31:0]        o_run_cycles;

    modport master (
        output i_start, i_abort, i_num_layers, i_param_loaded, i_last,
        input  o_load_state, o_current_layer, o_busy, o_done, o_err, o_irq, o_run_cycles
    );

    modport slave (
        input  i_start, i_abort, i_num_layers, i_param_loaded, i_last,
        output o_load_state, o_current_layer, o_busy, o_done, o_err, o_irq, o_run_cycles
    );

endinterface

// File: rtl/seq_watchdog.sv
// seq_watchdog: phase watchdog; expire is high while W cycles' worth of all-ones has been reached.
//   clk, rst_n  clock, async active-low reset
//   clr         restart count (a state transition)
//   en          the cycle being entered is a watched cycle
//   expire      registered, high in the (2^W-1)-th consecutive watched cycle
module seq_watchdog #(
    parameter int W = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    // The count includes the cycle being entered, so expire lines up with the last allowed cycle.
    assign cnt_nxt = (clr ? '0 : cnt) + W'(en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            expire <= &cnt_nxt;
        end
    end

endmodule

// File: rtl/conv_layer_seq.sv
// conv_layer_seq: multi-layer inference sequencer driving in_buffer load-state/layer selectors.
//   s_axi_aclk, s_axi_aresetn  clock, async active-low reset
//   bus (conv_layer_seq_if.slave)  commands, in_buffer pulses, selectors and status
//   Define CONV_LAYER_SEQ_PERF_EN to build the busy-cycle counter on o_run_cycles; otherwise it reads 0.
module conv_layer_seq
    import conv_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int TIMEOUT_W    = 24
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    conv_layer_seq_if.slave   bus
);

    state_t             state;
    state_t             next;
    logic [LAYER_W-1:0] num_q;
    logic [7:0]         drain_cnt;
    logic               wd_expire;
    logic               wd_clr;
    logic               wd_en;
    logic               start_ok;
    logic               drain_end;
    logic               clr_status;

    assign start_ok   = state == S_IDLE && bus.i_start && !bus.i_abort;
    assign clr_status = start_ok || bus.i_abort;
    assign drain_end  = state == S_DRAIN && next == S_LOAD_PARAM;
    assign wd_clr     = state != next;
    assign wd_en      = is_watched(next);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)
            state <= S_IDLE;
        else
            state <= next;
    end

    // Progress pulses beat the watchdog when they coincide with expiry; abort beats everything.
    always_comb begin
        next = state;
        case (state)
            S_IDLE:       next = bus.i_start ? S_LOAD_PARAM : S_IDLE;
            S_LOAD_PARAM: next = bus.i_param_loaded ? S_LOAD_DATA : wd_expire ? S_ERROR : S_LOAD_PARAM;
            S_LOAD_DATA:  next = bus.i_last ? (bus.o_current_layer == num_q ? S_DONE : S_DRAIN)
                               : wd_expire ? S_ERROR : S_LOAD_DATA;
            S_DRAIN:      next = drain_cnt == 8'(DRAIN_CYCLES - 1) ? S_LOAD_PARAM : S_DRAIN;
            S_DONE:       next = S_IDLE;
            S_ERROR:      next = S_ERROR;
            default:      next = S_IDLE;
        endcase
        if (bus.i_abort)
            next = S_IDLE;
    end

    seq_watchdog #(.W(TIMEOUT_W)) u_wd (
        .clk    (s_axi_aclk),
        .rst_n  (s_axi_aresetn),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Outputs are registered from the next state so they change together with the state.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            num_q               <= '0;
            drain_cnt           <= '0;
            bus.o_load_state    <= LS_PARAM;
            bus.o_current_layer <= '0;
            bus.o_busy          <= 1'b0;
            bus.o_done          <= 1'b0;
            bus.o_err           <= 1'b0;
            bus.o_irq           <= 1'b0;
        end else begin
            num_q               <= start_ok ? bus.i_num_layers : num_q;
            drain_cnt           <= state == S_DRAIN ? drain_cnt + 8'd1 : 8'd0;
            bus.o_load_state    <= next == S_LOAD_DATA ? LS_DATA : LS_PARAM;
            bus.o_current_layer <= clr_status ? '0 : drain_end ? bus.o_current_layer + 1'b1 : bus.o_current_layer;
            bus.o_busy          <= is_busy(next);
            bus.o_done          <= clr_status ? 1'b0 : bus.o_done | (next == S_DONE);
            bus.o_err           <= clr_status ? 1'b0 : bus.o_err | (next == S_ERROR);
            bus.o_irq           <= next == S_DONE || (next == S_ERROR && state != S_ERROR);
        end
    end

`ifdef CONV_LAYER_SEQ_PERF_EN
    logic [31:0] run_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)
            run_q <= '0;
        else
            run_q <= start_ok ? '0 : run_q + 32'(bus.o_busy && run_q != '1);
    end

    assign bus.o_run_cycles = run_q;
`else
    assign bus.o_run_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_layer_seq.sv
// tb_conv_layer_seq: randomized self-checking bench for conv_layer_seq against a cycle-count model.
module tb_conv_layer_seq;
    import conv_pkg::*;

    localparam int D  = 4;
    localparam int TW = 6;

    logic s_axi_aclk    = 1'b0;
    logic s_axi_aresetn = 1'b0;
    int   checks  = 0;
    int   passed  = 0;
    int   irq_cnt = 0;
    int   cyc     = 0;

    conv_layer_seq_if bus ();

    conv_layer_seq #(.DRAIN_CYCLES(D), .TIMEOUT_W(TW)) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .bus           (bus)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
        cyc++;
        if (bus.o_irq === 1'b1)
            irq_cnt++;
    endtask

    task automatic do_start(input logic [1:0] n);
        bus.i_num_layers = n;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic do_param();
        bus.i_param_loaded = 1'b1;
        tick();
        bus.i_param_loaded = 1'b0;
    endtask

    task automatic do_last();
        bus.i_last = 1'b1;
        tick();
        bus.i_last = 1'b0;
    endtask

    task automatic do_abort();
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
    endtask

    task automatic test_reset();
        s_axi_aresetn = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.o_load_state, bus.o_current_layer, bus.o_busy, bus.o_done, bus.o_err, bus.o_irq, bus.o_run_cycles} !== '0)
            $display("FAIL reset: got busy=%b done=%b err=%b irq=%b ls=%b layer=%0d run=%0d want all 0",
                     bus.o_busy, bus.o_done, bus.o_err, bus.o_irq, bus.o_load_state, bus.o_current_layer, bus.o_run_cycles);
        else
            passed++;
        s_axi_aresetn = 1'b1;
        tick();
    endtask

    task automatic test_single_layer();
        int cs, cl, irq0;
        logic [31:0] exp_run;
        repeat (2) tick();
        irq0 = irq_cnt;
        cs = cyc;
        do_start(2'd0);
        checks++;
        if ({bus.o_busy, bus.o_load_state} !== {1'b1, LS_PARAM})
            $display("FAIL single_start: got busy=%b ls=%b want busy=1 ls=0", bus.o_busy, bus.o_load_state);
        else
            passed++;
        repeat (9) tick();
        do_param();
        checks++;
        if (bus.o_load_state !== LS_DATA)
            $display("FAIL single_ls: got ls=%b want 1", bus.o_load_state);
        else
            passed++;
        repeat (49) tick();
        cl = cyc;
        do_last();
        checks++;
        if ({bus.o_irq, bus.o_done, bus.o_busy, bus.o_current_layer} !== 5'b11000)
            $display("FAIL single_done: got irq=%b done=%b busy=%b layer=%0d want irq=1 done=1 busy=0 layer=0",
                     bus.o_irq, bus.o_done, bus.o_busy, bus.o_current_layer);
        else
            passed++;
`ifdef CONV_LAYER_SEQ_PERF_EN
        exp_run = 32'(cl - cs);
`else
        exp_run = 32'd0;
`endif
        checks++;
        if (bus.o_run_cycles !== exp_run)
            $display("FAIL single_run: got %0d want %0d", bus.o_run_cycles, exp_run);
        else
            passed++;
        tick();
        checks++;
        if (irq_cnt - irq0 !== 1 || bus.o_done !== 1'b1 || bus.o_irq !== 1'b0)
            $display("FAIL single_irq: got irqs=%0d done=%b irq=%b want irqs=1 done=1 irq=0",
                     irq_cnt - irq0, bus.o_done, bus.o_irq);
        else
            passed++;
    endtask

    task automatic test_multi_layer(input logic [1:0] n);
        int cs, cl, irq0;
        logic [31:0] exp_run;
        repeat (2) tick();
        irq0 = irq_cnt;
        cs = cyc;
        cl = cyc;
        do_start(n);
        checks++;
        if (bus.o_done !== 1'b0)
            $display("FAIL multi_done_clr: got done=%b want 0", bus.o_done);
        else
            passed++;
        for (int l = 0; l <= int'(n); l++) begin
            checks++;
            if ({bus.o_busy, bus.o_load_state, bus.o_current_layer} !== {1'b1, LS_PARAM, 2'(l)})
                $display("FAIL multi_layer_start: got busy=%b ls=%b layer=%0d want busy=1 ls=0 layer=%0d",
                         bus.o_busy, bus.o_load_state, bus.o_current_layer, l);
            else
                passed++;
            repeat ($urandom_range(0, 20)) tick();
            do_param();
            checks++;
            if (bus.o_load_state !== LS_DATA)
                $display("FAIL multi_ls: got ls=%b want 1 (layer %0d)", bus.o_load_state, l);
            else
                passed++;
            repeat ($urandom_range(0, 20)) tick();
            cl = cyc;
            do_last();
            if (l < int'(n)) begin
                for (int k = 0; k < D; k++) begin
                    checks++;
                    if ({bus.o_busy, bus.o_load_state, bus.o_current_layer} !== {1'b1, LS_PARAM, 2'(l)})
                        $display("FAIL multi_drain: got busy=%b ls=%b layer=%0d want busy=1 ls=0 layer=%0d at drain cycle %0d",
                                 bus.o_busy, bus.o_load_state, bus.o_current_layer, l, k);
                    else
                        passed++;
                    tick();
                end
            end
        end
        checks++;
        if ({bus.o_irq, bus.o_done, bus.o_busy, bus.o_current_layer} !== {3'b110, n})
            $display("FAIL multi_done: got irq=%b done=%b busy=%b layer=%0d want irq=1 done=1 busy=0 layer=%0d",
                     bus.o_irq, bus.o_done, bus.o_busy, bus.o_current_layer, n);
        else
            passed++;
`ifdef CONV_LAYER_SEQ_PERF_EN
        exp_run = 32'(cl - cs);
`else
        exp_run = 32'd0;
`endif
        checks++;
        if (bus.o_run_cycles !== exp_run)
            $display("FAIL multi_run: got %0d want %0d", bus.o_run_cycles, exp_run);
        else
            passed++;
        tick();
        checks++;
        if (irq_cnt - irq0 !== 1)
            $display("FAIL multi_irq_count: got %0d want 1", irq_cnt - irq0);
        else
            passed++;
    endtask

    task automatic test_param_with_last();
        repeat (2) tick();
        do_start(2'd0);
        bus.i_param_loaded = 1'b1;
        bus.i_last = 1'b1;
        tick();
        bus.i_param_loaded = 1'b0;
        bus.i_last = 1'b0;
        checks++;
        if ({bus.o_busy, bus.o_load_state, bus.o_done} !== 3'b110)
            $display("FAIL param_last: got busy=%b ls=%b done=%b want busy=1 ls=1 done=0",
                     bus.o_busy, bus.o_load_state, bus.o_done);
        else
            passed++;
        repeat (3) tick();
        checks++;
        if ({bus.o_busy, bus.o_load_state, bus.o_done} !== 3'b110)
            $display("FAIL param_last_hold: got busy=%b ls=%b done=%b want busy=1 ls=1 done=0",
                     bus.o_busy, bus.o_load_state, bus.o_done);
        else
            passed++;
        do_last();
        checks++;
        if ({bus.o_done, bus.o_busy} !== 2'b10)
            $display("FAIL param_last_end: got done=%b busy=%b want done=1 busy=0", bus.o_done, bus.o_busy);
        else
            passed++;
    endtask

    task automatic test_last_at_timeout();
        repeat (2) tick();
        do_start(2'd0);
        do_param();
        repeat (TW == 6 ? 62 : 0) tick();
        do_last();
        checks++;
        if ({bus.o_done, bus.o_err, bus.o_irq} !== 3'b101)
            $display("FAIL last_vs_timeout: got done=%b err=%b irq=%b want done=1 err=0 irq=1",
                     bus.o_done, bus.o_err, bus.o_irq);
        else
            passed++;
    endtask

    task automatic test_timeout();
        int k, irq0;
        repeat (2) tick();
        irq0 = irq_cnt;
        do_start(2'd0);
        k = 0;
        while (bus.o_err !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (k !== (1 << TW) - 1)
            $display("FAIL timeout_cycles: got %0d want %0d", k, (1 << TW) - 1);
        else
            passed++;
        checks++;
        if ({bus.o_irq, bus.o_busy, bus.o_load_state} !== 3'b100)
            $display("FAIL timeout_entry: got irq=%b busy=%b ls=%b want irq=1 busy=0 ls=0",
                     bus.o_irq, bus.o_busy, bus.o_load_state);
        else
            passed++;
        do_start(2'd0);
        repeat (3) tick();
        checks++;
        if ({bus.o_busy, bus.o_err} !== 2'b01 || irq_cnt - irq0 !== 1)
            $display("FAIL timeout_hold: got busy=%b err=%b irqs=%0d want busy=0 err=1 irqs=1",
                     bus.o_busy, bus.o_err, irq_cnt - irq0);
        else
            passed++;
        do_abort();
        checks++;
        if ({bus.o_busy, bus.o_err, bus.o_done} !== 3'b000)
            $display("FAIL timeout_abort: got busy=%b err=%b done=%b want all 0", bus.o_busy, bus.o_err, bus.o_done);
        else
            passed++;
    endtask

    task automatic test_abort_mid();
        int irq0;
        repeat (2) tick();
        do_start(2'd3);
        for (int l = 0; l < 2; l++) begin
            do_param();
            tick();
            do_last();
            repeat (D) tick();
        end
        checks++;
        if ({bus.o_current_layer, bus.o_load_state} !== {2'd2, LS_PARAM})
            $display("FAIL abort_setup: got layer=%0d ls=%b want layer=2 ls=0", bus.o_current_layer, bus.o_load_state);
        else
            passed++;
        do_param();
        repeat (5) tick();
        irq0 = irq_cnt;
        do_abort();
        checks++;
        if ({bus.o_busy, bus.o_current_layer, bus.o_done, bus.o_irq, bus.o_load_state} !== '0)
            $display("FAIL abort_mid: got busy=%b layer=%0d done=%b irq=%b ls=%b want all 0",
                     bus.o_busy, bus.o_current_layer, bus.o_done, bus.o_irq, bus.o_load_state);
        else
            passed++;
        repeat (3) tick();
        checks++;
        if (irq_cnt !== irq0 || bus.o_busy !== 1'b0)
            $display("FAIL abort_quiet: got irqs=%0d busy=%b want irqs=0 busy=0", irq_cnt - irq0, bus.o_busy);
        else
            passed++;
    endtask

    task automatic test_start_abort_and_busy();
        repeat (2) tick();
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        tick();
        checks++;
        if ({bus.o_busy, bus.o_load_state} !== 2'b00)
            $display("FAIL start_abort: got busy=%b ls=%b want busy=0 ls=0", bus.o_busy, bus.o_load_state);
        else
            passed++;
        do_start(2'd1);
        do_start(2'd3);
        checks++;
        if ({bus.o_busy, bus.o_current_layer} !== 3'b100)
            $display("FAIL start_busy: got busy=%b layer=%0d want busy=1 layer=0", bus.o_busy, bus.o_current_layer);
        else
            passed++;
        do_param();
        do_last();
        checks++;
        if ({bus.o_busy, bus.o_done} !== 2'b10)
            $display("FAIL start_busy_l0: got busy=%b done=%b want busy=1 done=0", bus.o_busy, bus.o_done);
        else
            passed++;
        repeat (D) tick();
        do_param();
        do_last();
        checks++;
        if ({bus.o_done, bus.o_irq, bus.o_current_layer} !== 4'b1101)
            $display("FAIL start_busy_count: got done=%b irq=%b layer=%0d want done=1 irq=1 layer=1",
                     bus.o_done, bus.o_irq, bus.o_current_layer);
        else
            passed++;
    endtask

    task automatic test_reset_drain();
        repeat (2) tick();
        do_start(2'd1);
        do_param();
        do_last();
        tick();
        #3;
        s_axi_aresetn = 1'b0;
        #1;
        checks++;
        if ({bus.o_load_state, bus.o_current_layer, bus.o_busy, bus.o_done, bus.o_err, bus.o_irq, bus.o_run_cycles} !== '0)
            $display("FAIL reset_drain: got busy=%b done=%b err=%b irq=%b ls=%b layer=%0d run=%0d want all 0",
                     bus.o_busy, bus.o_done, bus.o_err, bus.o_irq, bus.o_load_state, bus.o_current_layer, bus.o_run_cycles);
        else
            passed++;
        #1;
        s_axi_aresetn = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.o_busy !== 1'b0)
            $display("FAIL reset_drain_idle: got busy=%b want 0", bus.o_busy);
        else
            passed++;
    endtask

    initial begin
        bus.i_start        = 1'b0;
        bus.i_abort        = 1'b0;
        bus.i_num_layers   = 2'd0;
        bus.i_param_loaded = 1'b0;
        bus.i_last         = 1'b0;
        test_reset();
        test_single_layer();
        test_multi_layer(2'd3);
        test_multi_layer(2'($urandom_range(0, 3)));
        test_param_with_last();
        test_last_at_timeout();
        test_timeout();
        test_abort_mid();
        test_start_abort_and_busy();
        test_reset_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
